// File: rtl/core_bus_arbiter_pkg.sv
// Shared types for the core bus arbiter: grant states, memory request/response
// channel structs and fixed fetch access size.
package core_bus_arbiter_pkg;

    localparam int ARB_ADDR_W = 64;
    localparam logic [2:0] MSIZE4 = 3'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic [ARB_ADDR_W-1:0] addr;
        logic [2:0]            size;
        logic [7:0]            strobe;
        logic [63:0]           data;
    } mreq_t;

    typedef struct packed {
        logic        ready;
        logic [63:0] data;
    } mresp_t;

endpackage

// File: rtl/core_bus_arbiter_checker.sv
// Protocol checks for the arbiter: requesters hold valid while served, and the
// memory/response handshakes stay mutually consistent.
module core_bus_arbiter_checker
    import core_bus_arbiter_pkg::*;
(
    input logic       clk,
    input logic       reset,
    input arb_state_t state,
    input logic       ireq_valid,
    input logic       dreq_valid,
    input logic       iresp_data_ok,
    input logic       dresp_data_ok,
    input logic       mreq_valid
);

    a_ireq_held: assert property (@(posedge clk) disable iff (reset)
        (state == BUSY_I) |-> ireq_valid);

    a_dreq_held: assert property (@(posedge clk) disable iff (reset)
        (state == BUSY_D) |-> dreq_valid);

    a_one_resp: assert property (@(posedge clk) disable iff (reset)
        !(iresp_data_ok && dresp_data_ok));

    a_mreq_busy: assert property (@(posedge clk) disable iff (reset)
        mreq_valid |-> ((state == BUSY_I) || (state == BUSY_D)));

endmodule

// File: rtl/core_bus_arbiter_streak_counter.sv
// Counts consecutive dbus grants taken while ibus was waiting; saturates at MAX.
module arb_streak_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic sat
);

    localparam logic [3:0] MAX_C = 4'(MAX);

    logic [3:0] count_r;

    // Clear has priority; increments stop once the limit is reached
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if (clr) begin
            count_r <= 4'd0;
        end else if (inc && (count_r != MAX_C)) begin
            count_r <= count_r + 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign sat = (count_r == MAX_C);

endmodule

// File: rtl/core_bus_arbiter.sv
// Merges core fetch and load/store requests onto one single-beat memory channel,
// with dbus priority bounded by an ibus anti-starvation streak limit.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int D_STREAK_MAX = 4,
    parameter int ADDR_W       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_addr_ok,
    output logic              iresp_data_ok,
    output logic [31:0]       iresp_data,
    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [7:0]        dreq_strobe,
    input  logic [63:0]       dreq_data,
    output logic              dresp_addr_ok,
    output logic              dresp_data_ok,
    output logic [63:0]       dresp_data,
    output logic              mreq_valid,
    output logic              mreq_is_write,
    output logic [ADDR_W-1:0] mreq_addr,
    output logic [2:0]        mreq_size,
    output logic [7:0]        mreq_strobe,
    output logic [63:0]       mreq_data,
    input  logic              mresp_ready,
    input  logic [63:0]       mresp_data
);

    arb_state_t            state_r, state_n;
    mreq_t                 mreq_r, mreq_n;
    mresp_t                mresp_s;
    logic                  i_ok_r, i_ok_n, d_ok_r, d_ok_n;
    logic [31:0]           idata_r, idata_n;
    logic [63:0]           ddata_r, ddata_n;
    logic                  grant_i_s, grant_d_s, streak_sat_s;
    logic [ARB_ADDR_W-1:0] iaddr_ext_s, daddr_ext_s;

    assign mresp_s = '{ready: mresp_ready, data: mresp_data};

    // Widen core addresses into the package-wide request address field (ADDR_W <= 64)
    always_comb begin
        iaddr_ext_s = '0;
        daddr_ext_s = '0;
        iaddr_ext_s[ADDR_W-1:0] = ireq_addr;
        daddr_ext_s[ADDR_W-1:0] = dreq_addr;
    end

    arb_streak_counter #(.MAX(D_STREAK_MAX)) u_streak (
        .clk   (clk),
        .reset (reset),
        .clr   (grant_i_s || (grant_d_s && !ireq_valid)),
        .inc   (grant_d_s && ireq_valid),
        .sat   (streak_sat_s)
    );

    // Grant selection, request capture and response generation; every output is registered
    always_comb begin
        state_n       = state_r;
        mreq_n        = mreq_r;
        mreq_n.valid  = 1'b0;
        i_ok_n        = 1'b0;
        d_ok_n        = 1'b0;
        idata_n       = idata_r;
        ddata_n       = ddata_r;
        grant_i_s     = 1'b0;
        grant_d_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (dreq_valid && ireq_valid) begin
                    if (streak_sat_s) begin
                        grant_i_s = 1'b1;
                    end else begin
                        grant_d_s = 1'b1;
                    end
                end else if (dreq_valid) begin
                    grant_d_s = 1'b1;
                end else if (ireq_valid) begin
                    grant_i_s = 1'b1;
                end else begin
                    state_n = IDLE;
                end
                if (grant_d_s) begin
                    state_n = BUSY_D;
                    mreq_n  = '{valid: 1'b1, is_write: (|dreq_strobe), addr: daddr_ext_s,
                                size: dreq_size, strobe: dreq_strobe, data: dreq_data};
                end else if (grant_i_s) begin
                    state_n = BUSY_I;
                    mreq_n  = '{valid: 1'b1, is_write: 1'b0, addr: iaddr_ext_s,
                                size: MSIZE4, strobe: 8'h00, data: 64'h0};
                end else begin
                    mreq_n.valid = 1'b0;
                end
            end
            BUSY_I: begin
                mreq_n.valid = 1'b1;
                if (mresp_s.ready) begin
                    state_n      = RESP_I;
                    mreq_n.valid = 1'b0;
                    i_ok_n       = 1'b1;
                    idata_n      = mreq_r.addr[2] ? mresp_s.data[63:32] : mresp_s.data[31:0];
                end else begin
                    state_n = BUSY_I;
                end
            end
            BUSY_D: begin
                mreq_n.valid = 1'b1;
                if (mresp_s.ready) begin
                    state_n      = RESP_D;
                    mreq_n.valid = 1'b0;
                    d_ok_n       = 1'b1;
                    ddata_n      = mresp_s.data;
                end else begin
                    state_n = BUSY_D;
                end
            end
            RESP_I:  state_n = IDLE;
            RESP_D:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            mreq_r  <= '0;
            i_ok_r  <= 1'b0;
            d_ok_r  <= 1'b0;
            idata_r <= 32'h0;
            ddata_r <= 64'h0;
        end else begin
            state_r <= state_n;
            mreq_r  <= mreq_n;
            i_ok_r  <= i_ok_n;
            d_ok_r  <= d_ok_n;
            idata_r <= idata_n;
            ddata_r <= ddata_n;
        end
    end

    assign mreq_valid    = mreq_r.valid;
    assign mreq_is_write = mreq_r.is_write;
    assign mreq_addr     = mreq_r.addr[ADDR_W-1:0];
    assign mreq_size     = mreq_r.size;
    assign mreq_strobe   = mreq_r.strobe;
    assign mreq_data     = mreq_r.data;
    assign iresp_addr_ok = i_ok_r;
    assign iresp_data_ok = i_ok_r;
    assign iresp_data    = idata_r;
    assign dresp_addr_ok = d_ok_r;
    assign dresp_data_ok = d_ok_r;
    assign dresp_data    = ddata_r;

    core_bus_arbiter_checker u_checker (
        .clk           (clk),
        .reset         (reset),
        .state         (state_r),
        .ireq_valid    (ireq_valid),
        .dreq_valid    (dreq_valid),
        .iresp_data_ok (i_ok_r),
        .dresp_data_ok (d_ok_r),
        .mreq_valid    (mreq_r.valid)
    );

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Sits directly downstream of the core's instruction and data bus ports; the core's ireq/dreq are its inputs.
- Merges ibus (fetch) and dbus (load/store) requests onto one single-beat 64-bit memory request channel (mreq/mresp).
- Returns responses with the core's addr_ok/data_ok handshake.
- Owns grant FSM, request capture, fetch-word extraction and ibus anti-starvation.

Parameters:
- D_STREAK_MAX, 4, consecutive dbus grants allowed while ibus waits before ibus is forced a grant (1..15).
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ireq_valid  in  1  fetch request; held until iresp_data_ok
- ireq_addr  in  ADDR_W  fetch address, 4-byte aligned
- iresp_addr_ok  out  1  fetch accepted; pulses together with iresp_data_ok
- iresp_data_ok  out  1  fetch data valid, one-cycle pulse
- iresp_data  out  32  instruction word
- dreq_valid  in  1  data request; held until dresp_data_ok
- dreq_addr  in  ADDR_W  data address
- dreq_size  in  3  log2 bytes (0..3)
- dreq_strobe  in  8  byte enables; 0 = read, nonzero = write
- dreq_data  in  64  store data, lane-aligned
- dresp_addr_ok  out  1  pulses together with dresp_data_ok
- dresp_data_ok  out  1  data response, one-cycle pulse
- dresp_data  out  64  load data, full 64-bit word
- mreq_valid  out  1  memory request
- mreq_is_write  out  1  strobe nonzero
- mreq_addr  out  ADDR_W  request address
- mreq_size  out  3  ibus: fixed 2; dbus: dreq_size
- mreq_strobe  out  8  ibus: 0; dbus: dreq_strobe
- mreq_data  out  64  ibus: 0; dbus: dreq_data
- mresp_ready  in  1  memory completes current request this cycle
- mresp_data  in  64  read data, valid with mresp_ready

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D. Reset (sync) -> IDLE, streak counter 0, all outputs 0.
- IDLE: dreq_valid & ireq_valid -> BUSY_D, unless streak == D_STREAK_MAX, then BUSY_I. Only one valid -> its BUSY state. Neither -> stay.
- At the grant edge, addr/size/strobe/data of the winner are latched into a request register. mreq_* are driven only from this register, never combinationally from core inputs.
- Streak counter: increments on a dbus grant while ireq_valid=1; clears on any ibus grant, or on a dbus grant with ireq_valid=0. Saturates at D_STREAK_MAX.
- BUSY_x: mreq_valid=1 and fields stable every cycle. mresp_ready=1 -> latch mresp_data, go to RESP_x. Otherwise stay, with no timeout.
- RESP_I: iresp_addr_ok=iresp_data_ok=1 for exactly one cycle. iresp_data = latched[63:32] if latched addr[2]=1, else latched[31:0]. Next state IDLE.
- RESP_D: dresp_addr_ok=dresp_data_ok=1 for one cycle, dresp_data = latched word (writes return latched word, ignored by core). Next state IDLE.
- Latency: request visible in IDLE at cycle t -> mreq_valid from t+1. mresp_ready at cycle u -> data_ok at u+1. Earliest next grant is evaluated at u+2.
- mreq_valid is never 1 in IDLE or RESP states. At most one of iresp_data_ok/dresp_data_ok is ever 1.
- Reset mid-transaction: abandon the request. mreq_valid drops the next cycle and no data_ok is issued. The core reissues.
- mresp_ready while not BUSY: ignored.
- A requester dropping valid while in BUSY is a protocol violation (assertion). The transaction still completes and the response pulse is still issued.
- Address arithmetic: no modification; aligned-address handling belongs to the memory side.

Decomposition:
- Shared package (common): state enum arb_state_t, packed struct mreq_t {valid,is_write,addr,size,strobe,data}, mresp_t {ready,data}, constant MSIZE4=3'd2.
- One natural sub-module: arb_streak_counter (saturating counter with clear/increment/saturate flag).
- Everything else stays in core_bus_arbiter.

Test Plan:
- Lone fetch: ireq_valid=1, addr=0x8000_0004, memory ready after 2 cycles with data 0xDEADBEEF_00000013 -> iresp_data=0xDEADBEEF, one data_ok pulse; mreq_size=2, strobe=0.
- Simultaneous requests: both valid at IDLE -> dbus granted first (mreq_addr=dreq_addr, strobe 0x0F -> is_write=1); ibus served immediately after dresp_data_ok.
- Starvation: D_STREAK_MAX=4, dreq_valid and ireq_valid held high for 6 transactions -> grant order D,D,D,D,I,D.
- Memory stall: mresp_ready held 0 for 20 cycles in BUSY_D -> mreq fields constant all 20 cycles, no data_ok; ready at cycle 21 -> dresp_data_ok at 22.
- Reset mid-op: reset asserted in BUSY_I -> next cycle IDLE, mreq_valid=0, no iresp_data_ok; fetch after reset completes normally.
- Spurious mresp_ready=1 in IDLE with no requests -> no outputs change, state stays IDLE.
